// File: rtl/spi_msg_packetizer_pkg.sv
// Shared types and header field layout for the SPI message packetizer.
package spi_msg_packetizer_pkg;

   localparam int WORD_W      = 16;
   localparam int HDR_OVF_BIT = 15;
   localparam int HDR_TMO_BIT = 14;
   localparam int HDR_LEN_W   = 14;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_HEADER,
      ST_PAYLOAD,
      ST_TRAILER
   } pkt_state_e;

   function automatic logic [WORD_W-1:0] build_header(input logic ovf,
                                                      input logic tmo,
                                                      input logic [HDR_LEN_W-1:0] len);
      logic [WORD_W-1:0] hdr;
      hdr                  = '0;
      hdr[HDR_LEN_W-1:0]   = len;
      hdr[HDR_TMO_BIT]     = tmo;
      hdr[HDR_OVF_BIT]     = ovf;
      return hdr;
   endfunction

endpackage

// File: rtl/spi_msg_packetizer_ram.sv
// Simple dual-port word store for one message; read data appears one cycle after the address.
module msg_word_ram
   import spi_msg_packetizer_pkg::*;
#(
   parameter int DEPTH = 512,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic [WORD_W-1:0] wr_data_i,
   input  logic [AW-1:0]     rd_addr_i,
   output logic [WORD_W-1:0] rd_data_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];

   // A read of the address being written returns the old contents.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      rd_data_o <= mem_q[rd_addr_i];
   end

endmodule

// File: rtl/spi_msg_packetizer.sv
// Collects one SPI message of 16-bit words and replays it as header, payload and optional checksum.
// Optional feature: define PKT_CHECKSUM_EN to append a wrap-around sum trailer word.
module spi_msg_packetizer
   import spi_msg_packetizer_pkg::*;
#(
   parameter int MAX_WORDS   = 512,
   parameter int TIMEOUT_CYC = 48000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [WORD_W-1:0] in_data_i,
   input  logic              in_last_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [WORD_W-1:0] out_data_o,
   output logic              out_last_o,
   output logic [15:0]       msg_count_o,
   output logic              busy_o
);

   localparam int AW    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam int LEN_W = AW + 1;
   localparam int TW    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_WORDS);
   localparam logic [TW-1:0]    TMR_LAST = TW'(TIMEOUT_CYC - 1);

   pkt_state_e        state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic              ovf_q, ovf_d;
   logic              tmo_q, tmo_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              in_ready_q;
`ifdef PKT_CHECKSUM_EN
   logic [WORD_W-1:0] sum_q, sum_d;
`endif

   logic              accept;
   logic              at_last;
   logic              wr_en;
   logic              msg_done;
   logic [WORD_W-1:0] header;
   logic [WORD_W-1:0] ram_q;

   assign accept  = in_valid_i && in_ready_q;
   assign at_last = (rd_ptr_q == AW'(len_q - 1'b1));
   assign header  = build_header(ovf_q, tmo_q, HDR_LEN_W'(len_q));

   // Reading at the next pointer keeps ram_q equal to the word at rd_ptr_q, which gives a free prefetch.
   msg_word_ram #(
      .DEPTH (MAX_WORDS),
      .AW    (AW)
   ) u_ram (
      .clk_i     (clk_i),
      .wr_en_i   (wr_en),
      .wr_addr_i (len_q[AW-1:0]),
      .wr_data_i (in_data_i),
      .rd_addr_i (rd_ptr_d),
      .rd_data_o (ram_q)
   );

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      rd_ptr_d = rd_ptr_q;
      tmr_d    = tmr_q;
      ovf_d    = ovf_q;
      tmo_d    = tmo_q;
      cnt_d    = cnt_q;
      wr_en    = 1'b0;
      msg_done = 1'b0;
`ifdef PKT_CHECKSUM_EN
      sum_d    = sum_q;
`endif
      case (state_q)
         ST_IDLE, ST_COLLECT: begin
            if (accept) begin
               tmr_d = '0;
               if (len_q < LEN_MAX) begin
                  wr_en = 1'b1;
                  len_d = len_q + 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
               state_d = in_last_i ? ST_HEADER : ST_COLLECT;
            end else if (state_q == ST_COLLECT) begin
               if (tmr_q == TMR_LAST) begin
                  tmo_d   = 1'b1;
                  state_d = ST_HEADER;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
         end
         ST_HEADER: begin
            if (out_ready_i) begin
               state_d  = ST_PAYLOAD;
               rd_ptr_d = '0;
`ifdef PKT_CHECKSUM_EN
               sum_d    = header;
`endif
            end
         end
         ST_PAYLOAD: begin
            if (out_ready_i) begin
`ifdef PKT_CHECKSUM_EN
               sum_d = sum_q + ram_q;
`endif
               if (at_last) begin
`ifdef PKT_CHECKSUM_EN
                  state_d = ST_TRAILER;
`else
                  msg_done = 1'b1;
`endif
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
         end
         ST_TRAILER: begin
            if (out_ready_i) begin
               msg_done = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (msg_done) begin
         state_d  = ST_IDLE;
         len_d    = '0;
         rd_ptr_d = '0;
         tmr_d    = '0;
         ovf_d    = 1'b0;
         tmo_d    = 1'b0;
         cnt_d    = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         rd_ptr_q   <= '0;
         tmr_q      <= '0;
         ovf_q      <= 1'b0;
         tmo_q      <= 1'b0;
         cnt_q      <= '0;
         in_ready_q <= 1'b0;
`ifdef PKT_CHECKSUM_EN
         sum_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         rd_ptr_q   <= rd_ptr_d;
         tmr_q      <= tmr_d;
         ovf_q      <= ovf_d;
         tmo_q      <= tmo_d;
         cnt_q      <= cnt_d;
         in_ready_q <= (state_d == ST_IDLE) || (state_d == ST_COLLECT);
`ifdef PKT_CHECKSUM_EN
         sum_q      <= sum_d;
`endif
      end
   end

   // Outputs come only from registered state, so there is no input-to-output path.
   always_comb begin
      out_data_o = '0;
      case (state_q)
         ST_HEADER:  out_data_o = header;
         ST_PAYLOAD: out_data_o = ram_q;
`ifdef PKT_CHECKSUM_EN
         ST_TRAILER: out_data_o = sum_q;
`endif
         default:    out_data_o = '0;
      endcase
   end

   assign out_valid_o = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD) || (state_q == ST_TRAILER);
`ifdef PKT_CHECKSUM_EN
   assign out_last_o  = (state_q == ST_TRAILER);
`else
   assign out_last_o  = (state_q == ST_PAYLOAD) && at_last;
`endif
   assign in_ready_o  = in_ready_q;
   assign msg_count_o = cnt_q;
   assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_msg_packetizer.sv
// Self-checking bench for spi_msg_packetizer using a small store and short idle timeout.
module tb_spi_msg_packetizer;

   localparam int MAXW = 4;
   localparam int TMO  = 16;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [15:0] in_data_i;
   logic        in_last_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [15:0] out_data_o;
   logic        out_last_o;
   logic [15:0] msg_count_o;
   logic        busy_o;

   typedef struct {
      logic [15:0] d;
      logic        l;
   } word_t;

   typedef struct {
      int          n;
      bit          withLast;
      int          rdyMode;
      logic [15:0] hdr;
      int          tmoCyc;
   } vec_t;

   int          checks = 0;
   int          failures = 0;
   int          readyMode = 3;
   int          expCount = 0;
   logic [15:0] msgWords [8];
   word_t       got [$];
   word_t       expQ [$];
   bit          prevStall = 1'b0;
   logic [15:0] prevData;
   logic        prevLast;

   spi_msg_packetizer #(
      .MAX_WORDS   (MAXW),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .in_last_i   (in_last_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_last_o  (out_last_o),
      .msg_count_o (msg_count_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   // Drives the output-side back-pressure pattern unless the test takes manual control.
   always begin
      @(posedge clk);
      #1;
      case (readyMode)
         0: out_ready_i = 1'b1;
         1: out_ready_i = !out_ready_i;
         2: out_ready_i = ($urandom_range(0, 9) < 7);
         default: ;
      endcase
   end

   // Records handshakes and checks hold-during-stall and input blocking while emitting.
   always @(negedge clk) begin
      if (rst_i) begin
         prevStall = 1'b0;
      end else begin
         if (prevStall) begin
            checks++;
            if (!out_valid_o || out_data_o !== prevData || out_last_o !== prevLast) begin
               failures++;
               $display("[TB] FAIL stall_hold: got valid=%0b data=%h last=%0b, need valid=1 data=%h last=%0b",
                        out_valid_o, out_data_o, out_last_o, prevData, prevLast);
            end
         end
         if (out_valid_o) begin
            checks++;
            if (in_ready_o !== 1'b0) begin
               failures++;
               $display("[TB] FAIL in_ready_busy: got %0b, need 0", in_ready_o);
            end
         end
         if (out_valid_o && out_ready_i) got.push_back('{d: out_data_o, l: out_last_o});
         prevStall = out_valid_o && !out_ready_i;
         prevData  = out_data_o;
         prevLast  = out_last_o;
      end
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] want);
      checks++;
      if (actual !== want) begin
         failures++;
         $display("[TB] FAIL %s: got %h, need %h", name, actual, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int n, input bit withLast, input int gapMax);
      for (int i = 0; i < n; i++) begin
         bit acc;
         int tries;
         int g;
         in_valid_i = 1'b1;
         in_data_i  = msgWords[i];
         in_last_i  = withLast && (i == n - 1);
         acc   = 1'b0;
         tries = 0;
         while (!acc && tries < 100) begin
            @(negedge clk);
            acc = in_ready_o;
            tick();
            tries++;
         end
         check("accept_word", {31'd0, acc}, 32'd1);
         in_valid_i = 1'b0;
         in_last_i  = 1'b0;
         if (gapMax > 0 && i < n - 1) begin
            g = $urandom_range(0, gapMax);
            repeat (g) tick();
         end
      end
   endtask

   // Expected packet: header, the first min(n, MAXW) words, optional trailer sum.
   task automatic buildExpected(input int n, input logic [15:0] hdr);
      int          stored;
      logic [15:0] sum;
      stored = (n > MAXW) ? MAXW : n;
      expQ.delete();
      expQ.push_back('{d: hdr, l: 1'b0});
      sum = hdr;
      for (int i = 0; i < stored; i++) begin
         expQ.push_back('{d: msgWords[i], l: 1'b0});
         sum = sum + msgWords[i];
      end
`ifdef PKT_CHECKSUM_EN
      expQ.push_back('{d: sum, l: 1'b1});
`else
      expQ[expQ.size() - 1].l = 1'b1;
`endif
      expCount = (expCount + 1) % 65536;
   endtask

   function automatic logic [15:0] modelHeader(input int n, input bit tmo);
      logic [15:0] h;
      h = 16'((n > MAXW) ? MAXW : n);
      if (n > MAXW) h = h + 16'h8000;
      if (tmo) h = h + 16'h4000;
      return h;
   endfunction

   task automatic checkOutput(input string name);
      int t;
      t = 0;
      while (got.size() < expQ.size() && t < 400) begin
         tick();
         t++;
      end
      repeat (3) tick();
      check({name, "_len"}, 32'(got.size()), 32'(expQ.size()));
      for (int i = 0; i < expQ.size() && i < got.size(); i++) begin
         checks++;
         if (got[i].d !== expQ[i].d || got[i].l !== expQ[i].l) begin
            failures++;
            $display("[TB] FAIL %s_word%0d: got data=%h last=%0b, need data=%h last=%0b",
                     name, i, got[i].d, got[i].l, expQ[i].d, expQ[i].l);
         end
      end
      check({name, "_count"}, 32'(msg_count_o), 32'(expCount));
      check({name, "_busy"}, {31'd0, busy_o}, 32'd0);
      got.delete();
   endtask

   vec_t vecs [8];

   initial begin
      int cyc;
      vecs[0] = '{n: 3, withLast: 1, rdyMode: 0, hdr: 16'h0003, tmoCyc: -1};
      vecs[1] = '{n: 3, withLast: 1, rdyMode: 1, hdr: 16'h0003, tmoCyc: -1};
      vecs[2] = '{n: 6, withLast: 1, rdyMode: 0, hdr: 16'h8004, tmoCyc: -1};
      vecs[3] = '{n: 2, withLast: 0, rdyMode: 0, hdr: 16'h4002, tmoCyc: 16};
      vecs[4] = '{n: 1, withLast: 1, rdyMode: 2, hdr: 16'h0001, tmoCyc: -1};
      vecs[5] = '{n: 4, withLast: 1, rdyMode: 1, hdr: 16'h0004, tmoCyc: -1};
      vecs[6] = '{n: 5, withLast: 1, rdyMode: 0, hdr: 16'h8004, tmoCyc: -1};
      vecs[7] = '{n: 6, withLast: 0, rdyMode: 2, hdr: 16'hC004, tmoCyc: 16};

      rst_i       = 1'b1;
      in_valid_i  = 1'b0;
      in_data_i   = '0;
      in_last_i   = 1'b0;
      out_ready_i = 1'b0;
      repeat (3) tick();
      check("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      check("rst_out_data", 32'(out_data_o), 32'd0);
      check("rst_out_last", {31'd0, out_last_o}, 32'd0);
      check("rst_msg_count", 32'(msg_count_o), 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      rst_i = 1'b0;
      tick();

      for (int v = 0; v < 8; v++) begin
         readyMode = vecs[v].rdyMode;
         for (int i = 0; i < 8; i++) msgWords[i] = 16'h00A1 + 16'(i) * 16'h0011;
         applyStimulus(vecs[v].n, vecs[v].withLast, 0);
         if (vecs[v].tmoCyc > 0) begin
            cyc = 0;
            while (!out_valid_o && cyc < 100) begin
               tick();
               cyc++;
            end
            check($sformatf("vec%0d_tmo_latency", v), 32'(cyc), 32'(vecs[v].tmoCyc));
         end
         buildExpected(vecs[v].n, vecs[v].hdr);
         checkOutput($sformatf("vec%0d", v));
      end

      // Reset while the payload is streaming: the packet is abandoned.
      readyMode   = 3;
      out_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) msgWords[i] = 16'h00A1 + 16'(i) * 16'h0011;
      applyStimulus(3, 1'b1, 0);
      out_ready_i = 1'b1;
      tick();
      tick();
      out_ready_i = 1'b0;
      rst_i       = 1'b1;
      tick();
      check("midrst_seen_words", 32'(got.size()), 32'd2);
      if (got.size() >= 2) begin
         check("midrst_hdr", 32'(got[0].d), 32'h0003);
         check("midrst_word0", 32'(got[1].d), 32'h00A1);
      end
      check("midrst_out_valid", {31'd0, out_valid_o}, 32'd0);
      check("midrst_out_data", 32'(out_data_o), 32'd0);
      check("midrst_out_last", {31'd0, out_last_o}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready_o}, 32'd0);
      check("midrst_busy", {31'd0, busy_o}, 32'd0);
      check("midrst_count", 32'(msg_count_o), 32'd0);
      rst_i = 1'b0;
      got.delete();
      expCount = 0;
      readyMode = 0;
      tick();
      msgWords[0] = 16'h1234;
      msgWords[1] = 16'h5678;
      applyStimulus(2, 1'b1, 0);
      buildExpected(2, 16'h0002);
      checkOutput("post_rst");

`ifdef PKT_CHECKSUM_EN
      msgWords[0] = 16'hFFFF;
      msgWords[1] = 16'h0002;
      applyStimulus(2, 1'b1, 0);
      expQ.delete();
      expQ.push_back('{d: 16'h0002, l: 1'b0});
      expQ.push_back('{d: 16'hFFFF, l: 1'b0});
      expQ.push_back('{d: 16'h0002, l: 1'b0});
      expQ.push_back('{d: 16'h0003, l: 1'b1});
      expCount++;
      checkOutput("csum");
`endif

      readyMode = 2;
      for (int r = 0; r < 40; r++) begin
         int n;
         n = $urandom_range(1, 7);
         for (int i = 0; i < 8; i++) msgWords[i] = 16'($urandom);
         applyStimulus(n, 1'b1, 3);
         buildExpected(n, modelHeader(n, 1'b0));
         checkOutput($sformatf("rand%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog");
   end

endmodule
